csr_trap_ctrl: RTL
==================

Name: csr_trap_ctrl

Overview:
- Initiator side of the CSR access port. Sequences the machine-mode CSR writes and reads needed to take an interrupt and to execute MRET.
- Owns the CSR file's single read/write port while busy. The top level muxes csr_addr_o/csr_wdata_o/csr_wr_o/csr_rd_o onto the port when csr_own_o=1.
- Stalls the single-cycle core and redirects its PC.
- Tracks mstatus and mie by snooping core CSR writes, so no CSR read is needed to decide whether an interrupt is enabled.

Parameters:
MCAUSE_EXT, 32'h8000_000B, mcause value for machine external interrupt
MCAUSE_TMR, 32'h8000_0007, mcause value for machine timer interrupt

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous reset, active-low (rst=0 resets)
pc_i  in  32  PC of instruction currently presented to core
retire_i  in  1  instruction at pc_i is valid and at a commit boundary
mret_i  in  1  instruction at pc_i decodes as MRET
ext_irq_i  in  1  level external interrupt request
tmr_irq_i  in  1  level timer interrupt request
snoop_wr_i  in  1  core CSR write this cycle
snoop_addr_i  in  12  core CSR address (inst[31:20])
snoop_wdata_i  in  32  core CSR write data
csr_rdata_i  in  32  CSR file async read data
csr_addr_o  out  12  CSR address driven when owning port
csr_wdata_o  out  32  CSR write data
csr_wr_o  out  1  CSR write strobe
csr_rd_o  out  1  CSR read strobe
csr_own_o  out  1  controller owns CSR port (state != IDLE)
stall_o  out  1  suppress/hold current core instruction
redirect_o  out  1  one-cycle PC redirect pulse
redirect_pc_o  out  32  redirect target, valid when redirect_o=1

Behaviour:
- Reset (rst=0, async): state=IDLE, shadow_mstatus=0, shadow_mie=0, latched cause/pc=0. All outputs 0.
- Shadows:
  - In IDLE with no take, snoop_wr_i updates shadow_mstatus (addr 300) and shadow_mie (addr 304) from snoop_wdata_i.
  - Own writes to 300 also update shadow_mstatus.
  - Snoop is ignored in any cycle where stall_o=1.
- take_irq = (state==IDLE) & retire_i & shadow_mstatus[3] & ((ext_irq_i & shadow_mie[11]) | (tmr_irq_i & shadow_mie[7])).
  - Uses registered shadows only.
  - External has priority over timer.
- take_mret = (state==IDLE) & retire_i & mret_i & ~take_irq. Interrupt wins over a simultaneous MRET.
- IDLE: on take_irq or take_mret, stall_o=1 combinationally in the same cycle.
  - take_irq: latch pc_i into epc and the selected cause, then go to T_MEPC.
  - take_mret: go to R_MSTATUS.
- Trap sequence (stall_o=1, csr_own_o=1 throughout):
  - T_MEPC: addr 341, wr=1, wdata=epc.
  - T_MCAUSE: addr 342, wr=1, wdata=cause.
  - T_MSTATUS: addr 300, wr=1, wdata = shadow with [7]=old [3], [3]=0, [12:11]=2'b11.
  - T_JUMP: addr 305, rd=1, redirect_o=1, redirect_pc_o = {csr_rdata_i[31:2],2'b00}.
  - T_JUMP then returns to IDLE.
- MRET sequence:
  - R_MSTATUS: addr 300, wr=1, wdata = shadow with [3]=old [7], [7]=1.
  - R_JUMP: addr 341, rd=1, redirect_o=1, redirect_pc_o = {csr_rdata_i[31:2],2'b00}.
  - R_JUMP then returns to IDLE.
- Latency:
  - Trap: redirect 4 cycles after the accept cycle; 5 stalled cycles total.
  - MRET: redirect 2 cycles after accept; 3 stalled cycles total.
- In IDLE: csr_wr_o=csr_rd_o=csr_own_o=redirect_o=0, csr_addr_o=0, csr_wdata_o=0.
- IRQ lines are sampled only at accept. Deassertion mid-sequence does not abort it.
- A new request is evaluated first in the IDLE cycle after the jump state, using updated shadows. Nested traps are impossible because MIE=0 after a trap.
- Reset asserted mid-sequence: immediate return to IDLE. Partial CSR writes are not undone.

Optional Feature:
- Macro: CSR_TRAP_VECTORED_EN.
- Defined, in T_JUMP only: if csr_rdata_i[1:0]==2'b01, redirect_pc_o = {csr_rdata_i[31:2],2'b00} + 4*cause[4:0] (ext: base+0x2C, timer: base+0x1C). Otherwise direct mode.
- Undefined: always direct mode (base with [1:0] cleared). MRET behaviour is identical in both builds.

Test Plan:
- Reset: rst=0 mid T_MCAUSE -> next edge state IDLE, all outputs 0, stall_o=0; shadows cleared, so ext_irq_i=1 is not taken after release.
- Ext trap: snoop 300<-0x8, 304<-0x800; pc_i=0x100, retire_i=1, ext_irq_i=1 -> writes 341<-0x100, 342<-0x8000000B, 300<-0x1880; with mtvec=0x200, redirect_o=1 with 0x200 on the 4th edge after accept.
- Masked: MIE=1, mie=0x80, ext_irq_i=1 only -> no stall, csr_own_o stays 0; then tmr_irq_i=1 -> mcause 0x80000007.
- Priority: ext_irq_i=tmr_irq_i=mret_i=1 same cycle -> trap taken, mcause 0x8000000B, mepc=pc_i of the MRET.
- MRET: shadow mstatus=0x1880, mepc=0x104 -> write 300<-0x1888, redirect 0x104 two edges after accept, shadow MIE=1.
- Vectored (CSR_TRAP_VECTORED_EN): mtvec=0x201, timer trap -> redirect_pc_o=0x21C; build without macro -> 0x200.

Source files
------------

// File: rtl/csr_trap_ctrl.sv
// ---------------------------------------------------------------------------
// csr_trap_ctrl
//
// Initiator side of the CSR access port for a single-cycle machine-mode core.
// Takes machine external / timer interrupts and executes MRET by issuing a
// short fixed sequence of CSR writes and reads, while stalling the core and
// finally redirecting its PC.
//
// mstatus and mie are tracked in shadow registers by snooping the core's own
// CSR writes, so deciding whether an interrupt is enabled never costs a CSR
// read.
//
// Optional feature:
//   CSR_TRAP_VECTORED_EN  - when defined, a trap honours mtvec vectored mode
//                           (mtvec[1:0]==2'b01 -> base + 4*cause[4:0]).
//                           When undefined, traps always use direct mode.
//
// Ports:
//   clk            in   clock, all state on rising edge
//   rst            in   asynchronous reset, active-low
//   pc_i           in   PC of instruction presented to the core
//   retire_i       in   instruction at pc_i is valid at a commit boundary
//   mret_i         in   instruction at pc_i is MRET
//   ext_irq_i      in   level machine external interrupt request
//   tmr_irq_i      in   level machine timer interrupt request
//   snoop_wr_i     in   core CSR write this cycle
//   snoop_addr_i   in   core CSR address
//   snoop_wdata_i  in   core CSR write data
//   csr_rdata_i    in   CSR file asynchronous read data
//   csr_addr_o     out  CSR address while owning the port
//   csr_wdata_o    out  CSR write data
//   csr_wr_o       out  CSR write strobe
//   csr_rd_o       out  CSR read strobe
//   csr_own_o      out  controller owns the CSR port (not idle)
//   stall_o        out  suppress/hold the current core instruction
//   redirect_o     out  one-cycle PC redirect pulse
//   redirect_pc_o  out  redirect target, valid with redirect_o
//
// The port-control outputs are decoded from the registered state only; the
// accept-cycle stall and the jump target are necessarily combinational, since
// the core must be held in the very cycle a request is accepted and the
// target comes straight from the asynchronous CSR read.
// ---------------------------------------------------------------------------
module csr_trap_ctrl #(
  parameter logic [31:0] MCAUSE_EXT = 32'h8000_000B,
  parameter logic [31:0] MCAUSE_TMR = 32'h8000_0007
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_i,
  input  logic        retire_i,
  input  logic        mret_i,
  input  logic        ext_irq_i,
  input  logic        tmr_irq_i,
  input  logic        snoop_wr_i,
  input  logic [11:0] snoop_addr_i,
  input  logic [31:0] snoop_wdata_i,
  input  logic [31:0] csr_rdata_i,
  output logic [11:0] csr_addr_o,
  output logic [31:0] csr_wdata_o,
  output logic        csr_wr_o,
  output logic        csr_rd_o,
  output logic        csr_own_o,
  output logic        stall_o,
  output logic        redirect_o,
  output logic [31:0] redirect_pc_o
);

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MIE     = 12'h304;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_T_MEPC    = 3'd1,
    ST_T_MCAUSE  = 3'd2,
    ST_T_MSTATUS = 3'd3,
    ST_T_JUMP    = 3'd4,
    ST_R_MSTATUS = 3'd5,
    ST_R_JUMP    = 3'd6
  } state_t;

  state_t      state_r;
  logic [31:0] mstatus_r;   // shadow of mstatus
  logic        mie_ext_r;   // shadow of mie.MEIE (bit 11)
  logic        mie_tmr_r;   // shadow of mie.MTIE (bit 7)
  logic [31:0] epc_r;
  logic [31:0] cause_r;

  logic        irq_ext_s;
  logic        irq_tmr_s;
  logic        take_irq_s;
  logic        take_mret_s;
  logic [31:0] base_s;
  logic [31:0] trap_target_s;

  // mstatus on trap entry: MPIE <= MIE, MIE <= 0, MPP <= M.
  function automatic logic [31:0] trap_mstatus(input logic [31:0] ms);
    logic [31:0] r;
    r        = ms;
    r[7]     = ms[3];
    r[3]     = 1'b0;
    r[12:11] = 2'b11;
    return r;
  endfunction

  // mstatus on MRET: MIE <= MPIE, MPIE <= 1.
  function automatic logic [31:0] mret_mstatus(input logic [31:0] ms);
    logic [31:0] r;
    r    = ms;
    r[3] = ms[7];
    r[7] = 1'b1;
    return r;
  endfunction

  // Accept decision, from registered shadows only; never while in reset.
  always_comb begin
    irq_ext_s   = ext_irq_i & mie_ext_r;
    irq_tmr_s   = tmr_irq_i & mie_tmr_r;
    take_irq_s  = rst & (state_r == ST_IDLE) & retire_i & mstatus_r[3]
                  & (irq_ext_s | irq_tmr_s);
    take_mret_s = rst & (state_r == ST_IDLE) & retire_i & mret_i & ~take_irq_s;
  end

  // Jump target: base with mode bits cleared, optionally vectored for traps.
  always_comb begin
    base_s = csr_rdata_i & 32'hFFFF_FFFC;
`ifdef CSR_TRAP_VECTORED_EN
    if (csr_rdata_i[1:0] == 2'b01) begin
      trap_target_s = base_s + {25'd0, cause_r[4:0], 2'b00};
    end else begin
      trap_target_s = base_s;
    end
`else
    trap_target_s = base_s;
`endif
  end

  // CSR port, stall and redirect decode for the current state.
  always_comb begin
    csr_addr_o    = 12'h000;
    csr_wdata_o   = 32'h0000_0000;
    csr_wr_o      = 1'b0;
    csr_rd_o      = 1'b0;
    csr_own_o     = 1'b0;
    stall_o       = 1'b0;
    redirect_o    = 1'b0;
    redirect_pc_o = 32'h0000_0000;
    case (state_r)
      ST_IDLE: begin
        stall_o = take_irq_s | take_mret_s;
      end
      ST_T_MEPC: begin
        csr_own_o   = 1'b1;
        stall_o     = 1'b1;
        csr_wr_o    = 1'b1;
        csr_addr_o  = ADDR_MEPC;
        csr_wdata_o = epc_r;
      end
      ST_T_MCAUSE: begin
        csr_own_o   = 1'b1;
        stall_o     = 1'b1;
        csr_wr_o    = 1'b1;
        csr_addr_o  = ADDR_MCAUSE;
        csr_wdata_o = cause_r;
      end
      ST_T_MSTATUS: begin
        csr_own_o   = 1'b1;
        stall_o     = 1'b1;
        csr_wr_o    = 1'b1;
        csr_addr_o  = ADDR_MSTATUS;
        csr_wdata_o = trap_mstatus(mstatus_r);
      end
      ST_T_JUMP: begin
        csr_own_o     = 1'b1;
        stall_o       = 1'b1;
        csr_rd_o      = 1'b1;
        csr_addr_o    = ADDR_MTVEC;
        redirect_o    = 1'b1;
        redirect_pc_o = trap_target_s;
      end
      ST_R_MSTATUS: begin
        csr_own_o   = 1'b1;
        stall_o     = 1'b1;
        csr_wr_o    = 1'b1;
        csr_addr_o  = ADDR_MSTATUS;
        csr_wdata_o = mret_mstatus(mstatus_r);
      end
      ST_R_JUMP: begin
        csr_own_o     = 1'b1;
        stall_o       = 1'b1;
        csr_rd_o      = 1'b1;
        csr_addr_o    = ADDR_MEPC;
        redirect_o    = 1'b1;
        redirect_pc_o = base_s;
      end
      default: begin
        csr_addr_o = 12'h000;
      end
    endcase
  end

  // Sequencer state, shadows and latched trap context.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= ST_IDLE;
      mstatus_r <= 32'h0000_0000;
      mie_ext_r <= 1'b0;
      mie_tmr_r <= 1'b0;
      epc_r     <= 32'h0000_0000;
      cause_r   <= 32'h0000_0000;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (take_irq_s) begin
            epc_r   <= pc_i;
            // external wins when both are pending and enabled
            cause_r <= irq_ext_s ? MCAUSE_EXT : MCAUSE_TMR;
            state_r <= ST_T_MEPC;
          end else if (take_mret_s) begin
            state_r <= ST_R_MSTATUS;
          end else if (snoop_wr_i) begin
            // stall_o is low here, so the core write really happens
            if (snoop_addr_i == ADDR_MSTATUS) begin
              mstatus_r <= snoop_wdata_i;
            end else if (snoop_addr_i == ADDR_MIE) begin
              mie_ext_r <= snoop_wdata_i[11];
              mie_tmr_r <= snoop_wdata_i[7];
            end else begin
              mstatus_r <= mstatus_r;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_T_MEPC: begin
          state_r <= ST_T_MCAUSE;
        end
        ST_T_MCAUSE: begin
          state_r <= ST_T_MSTATUS;
        end
        ST_T_MSTATUS: begin
          mstatus_r <= trap_mstatus(mstatus_r);
          state_r   <= ST_T_JUMP;
        end
        ST_T_JUMP: begin
          state_r <= ST_IDLE;
        end
        ST_R_MSTATUS: begin
          mstatus_r <= mret_mstatus(mstatus_r);
          state_r   <= ST_R_JUMP;
        end
        ST_R_JUMP: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
